// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_BRANCH = 2'b10,
    EXT_UPPER  = 2'b11
  } ext_mode_e;

  localparam int IMM_STAGES = 2;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension: sign, zero, branch (sign then shift), upper.
module ext_core
  import imm_ext_pkg::*;
#(
  parameter int DTBITS  = 16,
  parameter int EXTBITS = 32,
  parameter int SHAMT   = 2
) (
  input  logic [DTBITS-1:0]  data,
  input  logic [1:0]         mode,
  output logic [EXTBITS-1:0] result
);

  logic signed [DTBITS-1:0] sdata;
  logic [EXTBITS-1:0]       sext;
  logic [EXTBITS-1:0]       zext;

  // Size casts keep these legal even when EXTBITS == DTBITS.
  assign sdata = $signed(data);
  assign sext  = EXTBITS'(sdata);
  assign zext  = EXTBITS'(data);

  always_comb begin
    result = sext;
    case (ext_mode_e'(mode))
      EXT_SIGN:   result = sext;
      EXT_ZERO:   result = zext;
      EXT_BRANCH: result = sext << SHAMT;
      EXT_UPPER:  result = zext << (EXTBITS - DTBITS);
      default:    result = sext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage immediate-extension pipeline with stall, flush and a delivered-result counter.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DTBITS  = 16,
  parameter int EXTBITS = 32,
  parameter int SHAMT   = 2,
  parameter int CNTBITS = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [DTBITS-1:0]  i_ext,
  input  logic [1:0]         i_mode,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic               o_valid,
  output logic [EXTBITS-1:0] o_ext,
  output logic               o_neg,
  output logic [CNTBITS-1:0] o_count
);

  if (EXTBITS < DTBITS + SHAMT) begin : g_bad_params
    $error("imm_ext_pipe: EXTBITS must be >= DTBITS + SHAMT");
  end

  // vld_pipe[1] is the S1 valid, vld_pipe[2] drives o_valid.
  logic [IMM_STAGES:1] vld_pipe;
  logic [DTBITS-1:0]   s1_ext;
  logic [1:0]          s1_mode;
  logic [EXTBITS-1:0]  core_res;

  ext_core #(
    .DTBITS (DTBITS),
    .EXTBITS(EXTBITS),
    .SHAMT  (SHAMT)
  ) u_core (
    .data  (s1_ext),
    .mode  (s1_mode),
    .result(core_res)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      s1_ext   <= '0;
      s1_mode  <= '0;
      o_ext    <= '0;
      o_neg    <= 1'b0;
      o_count  <= '0;
    end else if (i_flush) begin
      // Data is left stale; only the valid bits matter after a flush.
      vld_pipe <= '0;
    end else if (!i_stall) begin
      vld_pipe <= {vld_pipe[1], i_valid};
      s1_ext   <= i_ext;
      s1_mode  <= i_mode;
      o_ext    <= core_res;
      o_neg    <= core_res[EXTBITS-1];
      if (vld_pipe[1]) o_count <= o_count + 1'b1;
    end
  end

  assign o_valid = vld_pipe[IMM_STAGES];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: directed corner cases plus randomized traffic.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] ext;
  logic [1:0]  mode;
  logic        stall;
  logic        flush;
  logic        o_valid;
  logic [31:0] o_ext;
  logic        o_neg;
  logic [7:0]  o_count;

  imm_ext_pipe #(.DTBITS(16), .EXTBITS(32), .SHAMT(2), .CNTBITS(8)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(valid),
    .i_ext  (ext),
    .i_mode (mode),
    .i_stall(stall),
    .i_flush(flush),
    .o_valid(o_valid),
    .o_ext  (o_ext),
    .o_neg  (o_neg),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];
  int          exp_cnt = 0;
  logic [31:0] last_exp = '0;
  bit          held = 1'b0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension rules as plain arithmetic modulo 2^32.
  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
    longint unsigned v, s;
    v = longint'(d);
    s = (v >= 64'd32768) ? v + 64'd4294901760 : v;   // + 2^32 - 2^16
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(v);
      2'd2:    return 32'(s * 64'd4);
      default: return 32'(v * 64'd65536);
    endcase
  endfunction

  // Apply one cycle of inputs, then update the expected-result queue for that edge.
  task automatic step(input bit v, input logic [15:0] d, input logic [1:0] m,
                      input bit st, input bit fl, input bit rn);
    valid = v; ext = d; mode = m; stall = st; flush = fl; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      sb_q.delete();
      exp_cnt = 0;
    end else if (fl) begin
      sb_q.delete();
    end else if (!st && v) begin
      sb_q.push_back(ref_ext(d, m));
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) idle(1);
    idle(1);
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: remember whether the last edge held the pipe.
  always @(posedge clk) held = rst_n && !flush && stall;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid === 1'b1) begin
        if (held) begin
          chk("held_ext", o_ext, last_exp);
          chk("held_neg", 32'(o_neg), 32'(last_exp[31]));
        end else if (sb_q.size() == 0) begin
          chk("unexpected_valid", 32'(o_valid), 32'd0);
        end else begin
          last_exp = sb_q.pop_front();
          exp_cnt  = (exp_cnt + 1) % 256;
          chk("result_ext", o_ext, last_exp);
          chk("result_neg", 32'(o_neg), 32'(last_exp[31]));
        end
      end
      chk("count", 32'(o_count), 32'(exp_cnt));
    end
  end

  initial begin
    int saved;
    valid = 0; ext = 0; mode = 0; stall = 0; flush = 0; rst_n = 0;
    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ext",   o_ext,        32'd0);
    chk("rst_neg",   32'(o_neg),   32'd0);
    chk("rst_count", 32'(o_count), 32'd0);

    // Latency: nothing after one edge, result after two.
    step(1'b1, 16'hFFFF, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_first_edge", 32'(o_valid), 32'd0);
    idle(1);
    @(negedge clk);
    chk("lat_second_edge", 32'(o_valid), 32'd1);
    chk("ffff_sign", o_ext, 32'hFFFFFFFF);
    chk("ffff_sign_neg", 32'(o_neg), 32'd1);
    step(1'b1, 16'hFFFF, 2'd1, 1'b0, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("ffff_zero", o_ext, 32'h0000FFFF);
    chk("ffff_zero_neg", 32'(o_neg), 32'd0);
    step(1'b1, 16'h8001, 2'd2, 1'b0, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("branch_8001", o_ext, 32'hFFFE0004);
    step(1'b1, 16'h1234, 2'd3, 1'b0, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("upper_1234", o_ext, 32'h12340000);
    drain();

    // Four inputs with a three-cycle stall after the second.
    do_reset();
    step(1'b1, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h8002, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 2'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h7FFF, 2'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hABCD, 2'd3, 1'b0, 1'b0, 1'b1);
    drain();
    chk("stall_count4", 32'(o_count), 32'd4);

    // Flush with stall while two entries are in flight.
    do_reset();
    step(1'b1, 16'h1111, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h2222, 2'd1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    saved = 32'(o_count);
    step(1'b1, 16'h3333, 2'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_count", 32'(o_count), 32'(saved));
    drain();

    // Reset with an entry sitting in S1.
    step(1'b1, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h6666, 2'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_ext",   o_ext,        32'd0);
    chk("rst_mid_count", 32'(o_count), 32'd0);
    idle(3);

    // Counter wrap after 257 results.
    do_reset();
    for (int i = 0; i < 257; i++) step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b1);
    drain();
    chk("wrap_count", 32'(o_count), 32'd1);

    // Random traffic with occasional stall and flush.
    do_reset();
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 9) < 7), 16'($urandom), 2'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0), 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
